// File: rtl/rd_port_arbiter_if.sv
// rd_port_arbiter_if: bundles the requester-side (s_*) and memory-side (m_*) burst-read signals; master = arbiter view, slave = requester/memory environment view
interface rd_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0][AW-1:0] s_araddr;
  logic [NREQ-1:0][3:0] s_arburst;
  logic [NREQ-1:0] s_arvalid;
  logic [NREQ-1:0] s_arready;
  logic [DW-1:0] s_rdata;
  logic [NREQ-1:0] s_rvalid;
  logic [NREQ-1:0] s_rlast;
  logic [AW-1:0] m_araddr;
  logic [3:0] m_arburst;
  logic m_arvalid;
  logic m_arready;
  logic [DW-1:0] m_rdata;
  logic m_rvalid;
  logic m_rlast;
  modport master (
    input s_araddr, s_arburst, s_arvalid, m_arready, m_rdata, m_rvalid, m_rlast,
    output s_arready, s_rdata, s_rvalid, s_rlast, m_araddr, m_arburst, m_arvalid
  );
  modport slave (
    output s_araddr, s_arburst, s_arvalid, m_arready, m_rdata, m_rvalid, m_rlast,
    input s_arready, s_rdata, s_rvalid, s_rlast, m_araddr, m_arburst, m_arvalid
  );
endinterface

// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: round-robin one-burst-at-a-time sharing of a burst-read port; ports clk, rst_n, bus (rd_port_arbiter_if.master), grant, busy, len_err, stray_r
module rd_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NREQ = 2,
  parameter int GW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic clk,
  input  logic rst_n,
  rd_port_arbiter_if.master bus,
  output logic [GW-1:0] grant,
  output logic busy,
  output logic len_err,
  output logic stray_r
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nx;
  logic [GW-1:0] last_grant, pick;
  logic found;
  logic [4:0] beat_cnt;
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && bus.s_arvalid[(int'(last_grant) + i) % NREQ]) begin
        pick = GW'((int'(last_grant) + i) % NREQ);
        found = 1'b1;
      end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? ADDR : IDLE) :
               state == ADDR ? (bus.m_arready ? DATA : ADDR) :
               (bus.m_rvalid && bus.m_rlast ? IDLE : DATA);
    bus.s_arready = '0;
    bus.s_rvalid = '0;
    bus.s_rlast = '0;
    if (state == ADDR) bus.s_arready[grant] = bus.m_arready;
    if (state == DATA) begin
      bus.s_rvalid[grant] = bus.m_rvalid;
      bus.s_rlast[grant] = bus.m_rlast;
    end
  end
  assign bus.m_arvalid = state == ADDR;
  assign bus.s_rdata = DW'(bus.m_rdata);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= GW'(NREQ - 1);
      grant <= '0;
      beat_cnt <= '0;
      len_err <= 1'b0;
      stray_r <= 1'b0;
      bus.m_araddr <= AW'(0);
      bus.m_arburst <= '0;
    end else begin
      state <= state_nx;
      len_err <= 1'b0;
      if (bus.m_rvalid && state != DATA) stray_r <= 1'b1;
      if (state == IDLE && found) begin
        grant <= pick;
        bus.m_araddr <= bus.s_araddr[pick];
        bus.m_arburst <= bus.s_arburst[pick];
      end
      if (state == ADDR && bus.m_arready) beat_cnt <= '0;
      if (state == DATA && bus.m_rvalid) begin
        beat_cnt <= beat_cnt == 5'd16 ? beat_cnt : beat_cnt + 5'd1;
        if (bus.m_rlast) begin
          last_grant <= grant;
          len_err <= (beat_cnt + 5'd1) != ({1'b0, bus.m_arburst} + 5'd1);
        end
      end
    end
  end
endmodule
